// File: rtl/div_arbiter_if.sv
// Handshake and divider bundle for div_arbiter.
// slave is the arbiter's view; master is the requester/divider side.
interface div_arbiter_if;
  logic        req0;
  logic        req1;
  logic [11:0] a0;
  logic [11:0] a1;
  logic [5:0]  q0;
  logic [5:0]  q1;
  logic        ack0;
  logic        ack1;
  logic        rsp_valid;
  logic        rsp_id;
  logic [5:0]  rsp_quo;
  logic [5:0]  rsp_rem;
  logic [1:0]  rsp_err;
  logic        busy;
  logic        div_start;
  logic [11:0] div_A;
  logic [5:0]  div_Q;
  logic [5:0]  div_quo;
  logic [5:0]  div_rem;
  logic        div_done;

  modport slave (
    input  req0, req1, a0, a1, q0, q1,
    input  div_quo, div_rem, div_done,
    output ack0, ack1,
    output rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err,
    output busy, div_start, div_A, div_Q
  );

  modport master (
    output req0, req1, a0, a1, q0, q1,
    output div_quo, div_rem, div_done,
    input  ack0, ack1,
    input  rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err,
    input  busy, div_start, div_A, div_Q
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one restoring divider between two
// requesters, with overflow pre-check, stale-done guard and timeout.
module div_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  div_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        last, last_n;
  logic        id, id_n;
  logic [11:0] cap_a, cap_a_n;
  logic [5:0]  cap_q, cap_q_n;
  logic        ack0, ack0_n;
  logic        ack1, ack1_n;
  logic        rsp_valid, rsp_valid_n;
  logic        rsp_id, rsp_id_n;
  logic [5:0]  rsp_quo, rsp_quo_n;
  logic [5:0]  rsp_rem, rsp_rem_n;
  logic [1:0]  rsp_err, rsp_err_n;
  logic        div_start, div_start_n;
  logic [7:0]  timer, timer_n;
  logic        armed, armed_n;
  logic        grant;

  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_quo   = rsp_quo;
  assign bus.rsp_rem   = rsp_rem;
  assign bus.rsp_err   = rsp_err;
  assign bus.busy      = (state != IDLE);
  assign bus.div_start = div_start;
  assign bus.div_A     = cap_a;
  assign bus.div_Q     = cap_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state;
    last_n      = last;
    id_n        = id;
    cap_a_n     = cap_a;
    cap_q_n     = cap_q;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_id_n    = rsp_id;
    rsp_quo_n   = rsp_quo;
    rsp_rem_n   = rsp_rem;
    rsp_err_n   = rsp_err;
    div_start_n = 1'b0;
    timer_n     = timer;
    armed_n     = armed;
    grant       = 1'b0;
    unique case (state)
      IDLE: begin
        // Both requesting: the one not granted last wins.
        if (bus.req0 && bus.req1) grant = ~last;
        else                      grant = bus.req1;
        if (bus.req0 || bus.req1) begin
          id_n    = grant;
          last_n  = grant;
          cap_a_n = grant ? bus.a1 : bus.a0;
          cap_q_n = grant ? bus.q1 : bus.q0;
          ack0_n  = ~grant;
          ack1_n  = grant;
          state_n = CHECK;
        end
      end
      CHECK: begin
        // A high half >= Q would overflow 6 bits (also Q == 0).
        if (cap_a[11:6] >= cap_q) begin
          rsp_valid_n = 1'b1;
          rsp_id_n    = id;
          rsp_quo_n   = '0;
          rsp_rem_n   = '0;
          rsp_err_n   = 2'b01;
          state_n     = RESP;
        end else begin
          div_start_n = 1'b1;
          timer_n     = '0;
          armed_n     = 1'b0;
          state_n     = WAIT;
        end
      end
      WAIT: begin
        timer_n = timer + 8'd1;
        if (!bus.div_done) armed_n = 1'b1;
        // Done only counts once seen low after start.
        if (armed && bus.div_done) begin
          rsp_valid_n = 1'b1;
          rsp_id_n    = id;
          rsp_quo_n   = bus.div_quo;
          rsp_rem_n   = bus.div_rem;
          rsp_err_n   = 2'b00;
          state_n     = RESP;
        end else if (timer == TLAST) begin
          rsp_valid_n = 1'b1;
          rsp_id_n    = id;
          rsp_quo_n   = '0;
          rsp_rem_n   = '0;
          rsp_err_n   = 2'b10;
          state_n     = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      id        <= 1'b0;
      cap_a     <= '0;
      cap_q     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_quo   <= '0;
      rsp_rem   <= '0;
      rsp_err   <= '0;
      div_start <= 1'b0;
      timer     <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      id        <= id_n;
      cap_a     <= cap_a_n;
      cap_q     <= cap_q_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
      rsp_valid <= rsp_valid_n;
      rsp_id    <= rsp_id_n;
      rsp_quo   <= rsp_quo_n;
      rsp_rem   <= rsp_rem_n;
      rsp_err   <= rsp_err_n;
      div_start <= div_start_n;
      timer     <= timer_n;
      armed     <= armed_n;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: vector table, scoreboard of responses,
// behavioural divider with stale-done and hang options.
module tb_div_arbiter;
  localparam int TO = 64;

  typedef struct {
    logic       id;
    logic [5:0] quo;
    logic [5:0] rem;
    logic [1:0] err;
  } exp_t;

  typedef struct {
    logic        id;
    logic [11:0] a;
    logic [5:0]  q;
    logic [5:0]  quo;
    logic [5:0]  rem;
    logic [1:0]  err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  exp_t sb[$];
  int   ds_count = 0;
  int   start_cyc = 0;
  int   rsp_cyc = 0;
  int   ack_cyc = 0;
  bit   hang = 1'b0;
  bit   stale = 1'b0;
  int   cnt = 0;
  int   mquo = 0;
  int   mrem = 0;
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_arbiter_if bus();

  div_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Divider model: result after 4 cycles; stale keeps old done one cycle.
  always @(negedge clk) begin
    if (rst) begin
      bus.div_done = 1'b0;
      bus.div_quo  = '0;
      bus.div_rem  = '0;
      cnt = 0;
    end else if (bus.div_start) begin
      cnt = 4;
      if (bus.div_Q != 0) begin
        mquo = int'(bus.div_A) / int'(bus.div_Q);
        mrem = int'(bus.div_A) % int'(bus.div_Q);
      end
      if (!stale) bus.div_done = 1'b0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && !hang) begin
        bus.div_quo  = mquo[5:0];
        bus.div_rem  = mrem[5:0];
        bus.div_done = 1'b1;
      end else begin
        bus.div_done = 1'b0;
      end
    end
  end

  // Response monitor and scoreboard compare.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.div_start) begin
        ds_count++;
        start_cyc = cyc;
      end
      if (bus.rsp_valid) begin
        rsp_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          check("rsp_quo", 32'(bus.rsp_quo), 32'(e.quo));
          check("rsp_rem", 32'(bus.rsp_rem), 32'(e.rem));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic drive(input logic id, input logic [11:0] a,
                       input logic [5:0] q, input logic v);
    if (id) begin
      bus.a1 = a; bus.q1 = q; bus.req1 = v;
    end else begin
      bus.a0 = a; bus.q0 = q; bus.req0 = v;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_ack(input logic id, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(id ? bus.ack1 : bus.ack0) && k < 200);
  endtask

  task automatic do_job(input logic id, input logic [11:0] a,
                        input logic [5:0] q, input exp_t e);
    int k;
    int base;
    base = ds_count;
    sb.push_back(e);
    @(negedge clk);
    drive(id, a, q, 1'b1);
    wait_ack(id, k);
    check("ack_latency", 32'(k), 32'd1);
    ack_cyc = cyc;
    drive(id, a, q, 1'b0);
    drain();
    check("div_start_count", 32'(ds_count - base),
          (e.err == 2'b01) ? 32'd0 : 32'd1);
    if (e.err == 2'b00) begin
      check("start_latency", 32'(start_cyc - ack_cyc), 32'd1);
      check("rsp_latency", 32'(rsp_cyc - start_cyc), 32'd5);
    end
  endtask

  task automatic sim_pair(input logic first);
    int k;
    exp_t e0;
    exp_t e1;
    e0 = '{id: 1'b0, quo: 6'd29, rem: 6'd15, err: 2'b00};
    e1 = '{id: 1'b1, quo: 6'd28, rem: 6'd9, err: 2'b00};
    if (first) begin
      sb.push_back(e1); sb.push_back(e0);
    end else begin
      sb.push_back(e0); sb.push_back(e1);
    end
    @(negedge clk);
    drive(1'b0, 12'd856, 6'd29, 1'b1);
    drive(1'b1, 12'd345, 6'd12, 1'b1);
    wait_ack(first, k);
    check("pair_first_ack", 32'(k), 32'd1);
    check("pair_other_ack",
          32'(first ? bus.ack0 : bus.ack1), 32'd0);
    drive(first, first ? 12'd345 : 12'd856,
          first ? 6'd12 : 6'd29, 1'b0);
    wait_ack(~first, k);
    check("pair_second_ack_seen", 32'(k < 200), 32'd1);
    check("pair_order", 32'(sb.size()), 32'd1);
    drive(~first, first ? 12'd856 : 12'd345,
          first ? 6'd29 : 6'd12, 1'b0);
    drain();
  endtask

  initial begin
    int k;
    exp_t e;
    tbl[0] = '{1'b0, 12'd856,  6'd29, 6'd29, 6'd15, 2'b00};
    tbl[1] = '{1'b1, 12'd345,  6'd12, 6'd28, 6'd9,  2'b00};
    tbl[2] = '{1'b1, 12'd819,  6'd13, 6'd63, 6'd0,  2'b00};
    tbl[3] = '{1'b0, 12'h400,  6'd6,  6'd0,  6'd0,  2'b01};
    tbl[4] = '{1'b0, 12'h400,  6'd0,  6'd0,  6'd0,  2'b01};
    tbl[5] = '{1'b1, 12'd100,  6'd7,  6'd14, 6'd2,  2'b00};
    tbl[6] = '{1'b0, 12'd4095, 6'd63, 6'd0,  6'd0,  2'b01};
    tbl[7] = '{1'b1, 12'd4031, 6'd63, 6'd63, 6'd62, 2'b00};

    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.q0 = '0; bus.q1 = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl",
          32'({bus.ack0, bus.ack1, bus.rsp_valid, bus.rsp_id,
               bus.rsp_quo, bus.rsp_rem, bus.rsp_err,
               bus.busy, bus.div_start}), 32'd0);
    check("reset_ops", 32'({bus.div_A, bus.div_Q}), 32'd0);
    rst = 1'b0;

    // Simultaneous from reset: requester 0 first.
    sim_pair(1'b0);
    // Last grant was 1; after a lone 0 job, 1 wins the tie.
    e = '{id: 1'b0, quo: 6'd29, rem: 6'd15, err: 2'b00};
    do_job(1'b0, 12'd856, 6'd29, e);
    sim_pair(1'b1);

    for (int i = 0; i < 8; i++) begin
      e = '{id: tbl[i].id, quo: tbl[i].quo,
            rem: tbl[i].rem, err: tbl[i].err};
      do_job(tbl[i].id, tbl[i].a, tbl[i].q, e);
    end
    repeat (3) @(negedge clk);
    check("hold_quo", 32'(bus.rsp_quo), 32'd63);
    check("hold_rem", 32'(bus.rsp_rem), 32'd62);
    check("hold_valid_low", 32'(bus.rsp_valid), 32'd0);

    // Done still high from the previous job must be ignored.
    stale = 1'b1;
    e = '{id: 1'b1, quo: 6'd63, rem: 6'd0, err: 2'b00};
    do_job(1'b1, 12'd819, 6'd13, e);
    stale = 1'b0;

    // Divider that never finishes.
    hang = 1'b1;
    e = '{id: 1'b0, quo: 6'd0, rem: 6'd0, err: 2'b10};
    do_job(1'b0, 12'd856, 6'd29, e);
    check("timeout_latency", 32'(rsp_cyc - start_cyc), 32'(TO));
    hang = 1'b0;
    e = '{id: 1'b1, quo: 6'd28, rem: 6'd9, err: 2'b00};
    do_job(1'b1, 12'd345, 6'd12, e);

    // Reset in the middle of WAIT drops the job.
    hang = 1'b1;
    @(negedge clk);
    drive(1'b0, 12'd856, 6'd29, 1'b1);
    wait_ack(1'b0, k);
    drive(1'b0, 12'd856, 6'd29, 1'b0);
    k = 0;
    while (!bus.div_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_start_seen", 32'(bus.div_start), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_ctrl",
          32'({bus.ack0, bus.ack1, bus.rsp_valid, bus.rsp_id,
               bus.rsp_quo, bus.rsp_rem, bus.rsp_err,
               bus.busy, bus.div_start}), 32'd0);
    check("mid_reset_ops", 32'({bus.div_A, bus.div_Q}), 32'd0);
    rst = 1'b0;
    hang = 1'b0;
    repeat (TO + 8) @(negedge clk);
    check("mid_reset_idle", 32'(bus.busy), 32'd0);
    e = '{id: 1'b0, quo: 6'd29, rem: 6'd15, err: 2'b00};
    do_job(1'b0, 12'd856, 6'd29, e);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, max cycles in WAIT before a job is aborted (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0, req1  input  1 each  job request from requester 0/1; held high until matching ack.
REQ-005 a0, a1  input  12 each  dividend from requester 0/1; stable while req high.
REQ-006 q0, q1  input  6 each  divisor from requester 0/1; stable while req high.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse: operands of that requester captured.
REQ-008 rsp_valid  output  1  one-cycle pulse: response fields valid.
REQ-009 rsp_id  output  1  requester that owns the response.
REQ-010 rsp_quo, rsp_rem  output  6 each  quotient and remainder of the job.
REQ-011 rsp_err  output  2  00 ok, 01 overflow/divide-by-zero, 10 timeout.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 div_start  output  1  one-cycle start pulse to the shared restoring divider.
REQ-014 div_A  output 12, div_Q  output 6  operands to divider, driven from captured registers.
REQ-015 div_quo, div_rem  input  6 each; div_done  input  1  divider results and completion flag.

Function
REQ-016 FSM states SHALL be IDLE, CHECK, WAIT, RESP.
REQ-017 IDLE: when any req is high, the arbiter SHALL capture the granted requester's operands and id, pulse that ack for exactly the following cycle, and move to CHECK.
REQ-018 Arbitration SHALL be round-robin: single requester always wins; when both request, the requester not granted last wins; the last-grant pointer updates on each grant.
REQ-019 CHECK: if captured A[11:6] >= Q (covers Q=0), the block SHALL go to RESP with rsp_err=01, rsp_quo=0, rsp_rem=0, and no div_start.
REQ-020 CHECK otherwise: div_start SHALL be high for exactly one cycle (registered), the timer SHALL clear, the done-armed flag SHALL clear, and the state SHALL move to WAIT.
REQ-021 div_A/div_Q SHALL hold the captured operands from CHECK until the block returns to IDLE.
REQ-022 WAIT: the done-armed flag SHALL set on any cycle with div_done=0; completion SHALL be div_done=1 while armed, so a stale done held high from a previous job is ignored.
REQ-023 On completion, div_quo/div_rem SHALL be registered into rsp_quo/rsp_rem, rsp_err=00, and the state SHALL move to RESP.
REQ-024 The WAIT timer SHALL increment each cycle; if it reaches TIMEOUT-1 without completion, the state SHALL move to RESP with rsp_err=10 and quo/rem=0; completion takes priority in that same cycle.
REQ-025 RESP: rsp_valid SHALL be high for one cycle with rsp_id, then the state SHALL return to IDLE; response fields SHALL hold until the next RESP.
REQ-026 A req still high in the cycle after its ack SHALL be treated as a new job; requesters must drop req on ack.
REQ-027 Latency (ok path) SHALL be: req seen in IDLE -> ack +1 cycle -> div_start +2 -> rsp_valid one cycle after armed done.
REQ-028 Only one job SHALL be in flight; requests arriving while busy wait, with no loss or reorder beyond round-robin.

Reset
REQ-029 rst SHALL force IDLE, clear ack0/ack1, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err, busy, div_start, div_A, div_Q, timer and armed flag, and set the last-grant pointer to 1 so requester 0 wins first.
REQ-030 rst mid-job SHALL drop the job silently: no rsp_valid for it; rst has priority over all transitions.

Verification
REQ-031 req0, a0=12'b001101011000 (856), q0=29 -> ack0, div_start, then rsp_valid, rsp_id=0, quo=29, rem=15, err=00.
REQ-032 req1, a1=12'b000101011001 (345), q1=12 -> quo=28, rem=9, err=00; a1=12'b001100110011 (819), q1=13 -> quo=63, rem=0.
REQ-033 a0=12'h400, q0=6 and separately q0=0 -> err=01, quo=rem=0, div_start never asserted.
REQ-034 req0 and req1 asserted together from reset -> ack0 first, ack1 after rsp for id 0; repeat simultaneous -> grant order alternates.
REQ-035 divider model never raises done (TIMEOUT=64) -> rsp_valid with err=10 on the 64th WAIT cycle; next job completes normally.
REQ-036 rst pulsed during WAIT -> all outputs 0 next cycle, no rsp_valid; a new req0 afterwards completes correctly.
